doc_hw_sensor_cmd_seq: RTL

//  Parametrised sensor-command sequencer. Generates 2-beat Avalon-ST voltage (8'h18) and

---
 rtl/doc_hw_sensor_cmd_seq.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/doc_hw_sensor_cmd_seq.sv
// Sensor-command sequencer: round-robin voltage/temperature command packets on Avalon-ST
// with response timeout supervision. Optional retry-on-failure under DOC_SEQ_RETRY_EN.
module doc_hw_sensor_cmd_seq #(
  parameter int unsigned N_VOLT_CH   = 16,
  parameter int unsigned N_TEMP_CH   = 8,
  parameter int unsigned RSP_TIMEOUT = 1024,
  parameter int unsigned MAX_RETRY   = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable_i,
  input  logic [N_VOLT_CH-1:0] volt_ch_en_i,
  input  logic [N_TEMP_CH-1:0] temp_ch_en_i,
  input  logic                 command_ready_i,
  output logic                 command_valid_o,
  output logic [31:0]          command_data_o,
  output logic                 command_startofpacket_o,
  output logic                 command_endofpacket_o,
  input  logic                 response_i,
  input  logic                 is_good,
  output logic                 is_volt,
  output logic                 is_temp,
  output logic [N_VOLT_CH-1:0] current_voltage_channel,
  output logic [3:0]           current_temperature_channel,
  output logic                 busy_o,
  output logic                 timeout_o,
  output logic                 sweep_done_o
);

  localparam int unsigned L  = N_VOLT_CH + N_TEMP_CH;
  localparam int unsigned PW = $clog2(L);
  localparam int unsigned CW = $clog2(RSP_TIMEOUT);
`ifdef DOC_SEQ_RETRY_EN
  localparam int unsigned RW = $clog2(MAX_RETRY + 2);
  logic [RW-1:0] retry_cnt;
`else
  logic unused_ok;
  assign unused_ok = ^{is_good, 32'(MAX_RETRY)};
`endif

  typedef enum logic [1:0] {IDLE, SEND0, SEND1, WAIT_RSP} state_t;

  state_t         state;
  logic [PW-1:0]  ptr;
  logic           started;
  logic           adv;
  logic [CW-1:0]  cnt;

  logic [L-1:0]         en;
  logic [PW:0]          sum;
  logic [PW-1:0]        start_idx;
  logic [PW-1:0]        sel_idx;
  logic                 sel_found;
  logic [PW-1:0]        pick_idx;
  logic                 pick_ok;
  logic                 pick_volt;
  logic                 ptr_volt;
  logic [N_VOLT_CH-1:0] ptr_onehot;
  logic [3:0]           ptr_tidx;
  logic [31:0]          beat1;

  assign en = {temp_ch_en_i, volt_ch_en_i};

  // Next enabled list entry, scanning from ptr+1 (index 0 after reset) with wrap
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    sum       = '0;
    if (!started || ptr == PW'(L - 1)) start_idx = '0;
    else                               start_idx = ptr + PW'(1);
    for (int unsigned k = 0; k < L; k++) begin
      sum = {1'b0, start_idx} + (PW+1)'(k);
      if (sum >= (PW+1)'(L)) sum = sum - (PW+1)'(L);
      if (!sel_found && en[sum[PW-1:0]]) begin
        sel_found = 1'b1;
        sel_idx   = sum[PW-1:0];
      end
    end
    if (!adv && en[ptr]) begin
      pick_ok  = 1'b1;
      pick_idx = ptr;
    end else begin
      pick_ok  = sel_found;
      pick_idx = sel_idx;
    end
  end

  assign pick_volt  = pick_idx < PW'(N_VOLT_CH);
  assign ptr_volt   = ptr < PW'(N_VOLT_CH);
  assign ptr_onehot = N_VOLT_CH'(1) << ptr;
  assign ptr_tidx   = 4'(ptr - PW'(N_VOLT_CH));
  assign beat1      = ptr_volt ? 32'(ptr_onehot) : {12'h0, ptr_tidx, 16'h0};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state                       <= IDLE;
      ptr                         <= '0;
      started                     <= 1'b0;
      adv                         <= 1'b1;
      cnt                         <= '0;
      command_valid_o             <= 1'b0;
      command_data_o              <= '0;
      command_startofpacket_o     <= 1'b0;
      command_endofpacket_o       <= 1'b0;
      is_volt                     <= 1'b0;
      is_temp                     <= 1'b0;
      current_voltage_channel     <= '0;
      current_temperature_channel <= '0;
      busy_o                      <= 1'b0;
      timeout_o                   <= 1'b0;
      sweep_done_o                <= 1'b0;
`ifdef DOC_SEQ_RETRY_EN
      retry_cnt                   <= '0;
`endif
    end else begin
      timeout_o    <= 1'b0;
      sweep_done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (enable_i && pick_ok) begin
            state                   <= SEND0;
            busy_o                  <= 1'b1;
            command_valid_o         <= 1'b1;
            command_startofpacket_o <= 1'b1;
            command_endofpacket_o   <= 1'b0;
            command_data_o          <= pick_volt ? 32'h18 : 32'h19;
            is_volt                 <= pick_volt;
            is_temp                 <= !pick_volt;
            sweep_done_o            <= started && (pick_idx < ptr);
            ptr                     <= pick_idx;
            started                 <= 1'b1;
          end
        end
        SEND0: begin
          if (command_ready_i) begin
            state                   <= SEND1;
            command_startofpacket_o <= 1'b0;
            command_endofpacket_o   <= 1'b1;
            command_data_o          <= beat1;
          end
        end
        SEND1: begin
          if (command_ready_i) begin
            state                 <= WAIT_RSP;
            command_valid_o       <= 1'b0;
            command_endofpacket_o <= 1'b0;
            command_data_o        <= '0;
            if (ptr_volt) current_voltage_channel     <= ptr_onehot;
            else          current_temperature_channel <= ptr_tidx;
          end
        end
        WAIT_RSP: begin
          if (response_i || cnt == CW'(RSP_TIMEOUT - 1)) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            cnt       <= '0;
            timeout_o <= !response_i;
`ifdef DOC_SEQ_RETRY_EN
            // A failed attempt keeps the pointer so the same channel is re-issued
            if ((!response_i || !is_good) && retry_cnt < RW'(MAX_RETRY)) begin
              retry_cnt <= retry_cnt + RW'(1);
              adv       <= 1'b0;
            end else begin
              retry_cnt <= '0;
              adv       <= 1'b1;
            end
`else
            adv <= 1'b1;
`endif
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
